// File: rtl/clock_calendar_core_if.sv
// Control/display bundle for clock_calendar_core.
// Optional feature macro: CAL_DEC_EN (adds the dec request line).
// Requests (set_en/set_sel/inc/dec) are levels sampled on clk; there is no
// valid/ready pairing because every request is consumed on the edge it is seen.
interface clock_calendar_core_if;
  logic       set_en;
  logic [2:0] set_sel;
  logic       inc;
`ifdef CAL_DEC_EN
  logic       dec;
`endif
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [2:0] day;
  logic [4:0] date;
  logic [3:0] month;
  logic [5:0] year;
  logic       sec_tick;

  // Driver side: buttons / set-mode control, consumes the calendar fields.
  modport master (
    output set_en, set_sel, inc,
`ifdef CAL_DEC_EN
    output dec,
`endif
    input  sec, min, hour, day, date, month, year, sec_tick
  );

  // Calendar core side.
  modport slave (
    input  set_en, set_sel, inc,
`ifdef CAL_DEC_EN
    input  dec,
`endif
    output sec, min, hour, day, date, month, year, sec_tick
  );
endinterface

// File: rtl/clock_calendar_core.sv
// Clock/calendar core: prescaler to 1 Hz, cascaded sec..year chain with
// month-length and leap-year rules, and a one-field-at-a-time set mode.
// Optional feature macro: CAL_DEC_EN (dec button decrements the selected field).
module clock_calendar_core #(
  parameter int TICK_DIV = 50000000,
  parameter int PRESC_W  = 26
) (
  input logic                  clk,
  input logic                  rst,
  clock_calendar_core_if.slave bus
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic [2:0] day_q, day_d;
  logic [4:0] date_q, date_d;
  logic [3:0] month_q, month_d;
  logic [5:0] year_q, year_d;
  logic       sec_tick_q, sec_tick_d;
  logic       inc_q, inc_d;
`ifdef CAL_DEC_EN
  logic       dec_q, dec_d;
`endif

  logic       inc_edge;
  logic       dec_edge;
  logic       do_edit;
  logic       up;
  logic [4:0] dim_cur;
  logic [4:0] dim_new;

  // Feb has 29 days whenever year[1:0]==0; exact across 2000..2063.
  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [5:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  // Next-state: button edges, prescaler, carry chain and set-mode edits.
  always_comb begin
    presc_d    = presc_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    day_d      = day_q;
    date_d     = date_q;
    month_d    = month_q;
    year_d     = year_q;
    sec_tick_d = 1'b0;
    inc_d      = bus.inc;
    inc_edge   = bus.inc & ~inc_q;
`ifdef CAL_DEC_EN
    dec_d      = bus.dec;
    dec_edge   = bus.dec & ~dec_q;
`else
    dec_edge   = 1'b0;
`endif
    // Simultaneous inc and dec edges cancel out.
    do_edit    = inc_edge ^ dec_edge;
    up         = inc_edge;
    dim_cur    = days_in_month(month_q, year_q);
    dim_new    = dim_cur;

    if (bus.set_en) begin
      // Time frozen; prescaler parked so the first tick after exit is a full period away.
      presc_d = '0;
      if (do_edit) begin
        case (bus.set_sel)
          3'd1: sec_d  = up ? ((sec_q  == 6'd59) ? 6'd0  : sec_q  + 6'd1)
                            : ((sec_q  == 6'd0)  ? 6'd59 : sec_q  - 6'd1);
          3'd2: min_d  = up ? ((min_q  == 6'd59) ? 6'd0  : min_q  + 6'd1)
                            : ((min_q  == 6'd0)  ? 6'd59 : min_q  - 6'd1);
          3'd3: hour_d = up ? ((hour_q == 5'd23) ? 5'd0  : hour_q + 5'd1)
                            : ((hour_q == 5'd0)  ? 5'd23 : hour_q - 5'd1);
          3'd4: day_d  = up ? ((day_q  == 3'd6)  ? 3'd0  : day_q  + 3'd1)
                            : ((day_q  == 3'd0)  ? 3'd6  : day_q  - 3'd1);
          3'd5: date_d = up ? ((date_q >= dim_cur) ? 5'd1 : date_q + 5'd1)
                            : ((date_q <= 5'd1)    ? dim_cur : date_q - 5'd1);
          3'd6: begin
            month_d = up ? ((month_q == 4'd12) ? 4'd1  : month_q + 4'd1)
                         : ((month_q == 4'd1)  ? 4'd12 : month_q - 4'd1);
            dim_new = days_in_month(month_d, year_q);
            if (date_q > dim_new) date_d = dim_new;
          end
          3'd7: begin
            // 6-bit wrap gives 63->0 and 0->63 directly.
            year_d  = up ? year_q + 6'd1 : year_q - 6'd1;
            dim_new = days_in_month(month_q, year_d);
            if (date_q > dim_new) date_d = dim_new;
          end
          default: ;
        endcase
      end
    end else if (presc_q == PRESC_LAST) begin
      presc_d    = '0;
      sec_tick_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d = 5'd0;
            day_d  = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
            if (date_q >= dim_cur) begin
              date_d = 5'd1;
              if (month_q == 4'd12) begin
                month_d = 4'd1;
                year_d  = year_q + 6'd1;
              end else begin
                month_d = month_q + 4'd1;
              end
            end else begin
              date_d = date_q + 5'd1;
            end
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // State registers; reset lands on 2000-01-01 00:00:00, a Saturday.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 5'd0;
      day_q      <= 3'd6;
      date_q     <= 5'd1;
      month_q    <= 4'd1;
      year_q     <= 6'd0;
      sec_tick_q <= 1'b0;
      inc_q      <= 1'b0;
`ifdef CAL_DEC_EN
      dec_q      <= 1'b0;
`endif
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      date_q     <= date_d;
      month_q    <= month_d;
      year_q     <= year_d;
      sec_tick_q <= sec_tick_d;
      inc_q      <= inc_d;
`ifdef CAL_DEC_EN
      dec_q      <= dec_d;
`endif
    end
  end

  assign bus.sec      = sec_q;
  assign bus.min      = min_q;
  assign bus.hour     = hour_q;
  assign bus.day      = day_q;
  assign bus.date     = date_q;
  assign bus.month    = month_q;
  assign bus.year     = year_q;
  assign bus.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_clock_calendar_core.sv
// Directed bench for clock_calendar_core with TICK_DIV=4.
module tb_clock_calendar_core;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  clock_calendar_core_if bus ();

  clock_calendar_core #(.TICK_DIV(4), .PRESC_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fields packed as {sec,min,hour,day,date,month,year} = 35 bits.
  function automatic logic [34:0] pack(input int s, input int mi, input int h,
                                       input int dy, input int dt, input int mo, input int y);
    pack = {6'(s), 6'(mi), 5'(h), 3'(dy), 5'(dt), 4'(mo), 6'(y)};
  endfunction

  logic [34:0] got;
  assign got = {bus.sec, bus.min, bus.hour, bus.day, bus.date, bus.month, bus.year};

  // Drivers
  task automatic start_set();
    rst = 1'b1;
    bus.set_en = 1'b1;
    bus.inc = 1'b0;
    bus.set_sel = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic edit(input logic [2:0] sel, input int n);
    @(negedge clk);
    bus.set_sel = sel;
    repeat (n) begin
      @(negedge clk) bus.inc = 1'b1;
      @(negedge clk) bus.inc = 1'b0;
    end
  endtask

  // Leave set mode and stop right after the first tick edge.
  task automatic exit_and_tick(input string name);
    @(negedge clk);
    bus.set_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus.sec_tick !== 1'b1) begin
      bad++;
      $display("FAIL %s_tick: got %b want 1", name, bus.sec_tick);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    logic exp_tick;
    rst = 1'b1;
    bus.set_en = 1'b0;
    bus.set_sel = 3'd0;
    bus.inc = 1'b0;
    #12;
    total++;
    if (got !== pack(0, 0, 0, 6, 1, 1, 0) || bus.sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got %h tick %b want %h tick 0", got, bus.sec_tick, pack(0, 0, 0, 6, 1, 1, 0));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      exp_tick = (i == 3 || i == 7);
      total++;
      if (bus.sec_tick !== exp_tick) begin
        bad++;
        $display("FAIL run_tick_cycle%0d: got %b want %b", i + 1, bus.sec_tick, exp_tick);
      end
    end
    total++;
    if (got !== pack(2, 0, 0, 6, 1, 1, 0)) begin
      bad++;
      $display("FAIL run_8_cycles: got %h want %h", got, pack(2, 0, 0, 6, 1, 1, 0));
    end
  endtask

  task automatic test_day_rollover();
    start_set();
    edit(3'd7, 1);   // year 1
    edit(3'd6, 1);   // Feb
    edit(3'd5, 27);  // date 28
    edit(3'd3, 23);
    edit(3'd2, 59);
    edit(3'd1, 59);
    edit(3'd4, 4);   // 6 -> 3
    total++;
    if (got !== pack(59, 59, 23, 3, 28, 2, 1)) begin
      bad++;
      $display("FAIL set_fields: got %h want %h", got, pack(59, 59, 23, 3, 28, 2, 1));
    end
    exit_and_tick("feb28");
    total++;
    if (got !== pack(0, 0, 0, 4, 1, 3, 1)) begin
      bad++;
      $display("FAIL feb28_rollover: got %h want %h", got, pack(0, 0, 0, 4, 1, 3, 1));
    end
  endtask

  task automatic test_leap();
    start_set();
    edit(3'd7, 4);
    edit(3'd6, 1);
    edit(3'd5, 27);
    edit(3'd3, 23);
    edit(3'd2, 59);
    edit(3'd1, 59);
    edit(3'd4, 4);
    exit_and_tick("leap28");
    total++;
    if (got !== pack(0, 0, 0, 4, 29, 2, 4)) begin
      bad++;
      $display("FAIL leap_feb29: got %h want %h", got, pack(0, 0, 0, 4, 29, 2, 4));
    end
    @(negedge clk);
    bus.set_en = 1'b1;
    edit(3'd3, 23);
    edit(3'd2, 59);
    edit(3'd1, 59);
    exit_and_tick("leap29");
    total++;
    if (got !== pack(0, 0, 0, 5, 1, 3, 4)) begin
      bad++;
      $display("FAIL leap_rollover: got %h want %h", got, pack(0, 0, 0, 5, 1, 3, 4));
    end
  endtask

  task automatic test_year_wrap();
    start_set();
    edit(3'd7, 63);
    edit(3'd6, 11);
    edit(3'd5, 30);
    edit(3'd3, 23);
    edit(3'd2, 59);
    edit(3'd1, 59);
    exit_and_tick("dec31");
    total++;
    if (got !== pack(0, 0, 0, 0, 1, 1, 0)) begin
      bad++;
      $display("FAIL year_wrap: got %h want %h", got, pack(0, 0, 0, 0, 1, 1, 0));
    end
  endtask

  task automatic test_set_edits();
    start_set();
    edit(3'd7, 1);
    edit(3'd5, 30);
    edit(3'd6, 1);
    total++;
    if (bus.month !== 4'd2 || bus.date !== 5'd28) begin
      bad++;
      $display("FAIL month_clamp: got m%0d d%0d want m2 d28", bus.month, bus.date);
    end
    // Held button gives one step.
    @(negedge clk);
    bus.inc = 1'b1;
    repeat (20) @(negedge clk);
    bus.inc = 1'b0;
    @(negedge clk);
    total++;
    if (bus.month !== 4'd3 || bus.date !== 5'd28) begin
      bad++;
      $display("FAIL inc_hold: got m%0d d%0d want m3 d28", bus.month, bus.date);
    end
    // Run mode ignores inc.
    bus.set_en = 1'b0;
    @(negedge clk) bus.inc = 1'b1;
    @(negedge clk) bus.inc = 1'b0;
    total++;
    if (bus.month !== 4'd3 || bus.date !== 5'd28 || bus.year !== 6'd1) begin
      bad++;
      $display("FAIL run_inc_ignored: got m%0d d%0d y%0d want m3 d28 y1", bus.month, bus.date, bus.year);
    end
    // Select change while inc is held: only the edge counts.
    @(negedge clk);
    bus.set_en = 1'b1;
    @(negedge clk);
    bus.set_sel = 3'd6;
    bus.inc = 1'b1;
    @(negedge clk);
    bus.set_sel = 3'd7;
    repeat (5) @(negedge clk);
    bus.inc = 1'b0;
    @(negedge clk);
    total++;
    if (bus.month !== 4'd4 || bus.year !== 6'd1) begin
      bad++;
      $display("FAIL sel_change_held: got m%0d y%0d want m4 y1", bus.month, bus.year);
    end
    // Year edit clamps 29 Feb (2004) to 28 Feb (2005).
    edit(3'd6, 10);
    edit(3'd7, 3);
    edit(3'd5, 1);
    total++;
    if (bus.date !== 5'd29 || bus.month !== 4'd2 || bus.year !== 6'd4) begin
      bad++;
      $display("FAIL leap_set: got d%0d m%0d y%0d want d29 m2 y4", bus.date, bus.month, bus.year);
    end
    edit(3'd7, 1);
    total++;
    if (bus.date !== 5'd28 || bus.year !== 6'd5) begin
      bad++;
      $display("FAIL year_clamp: got d%0d y%0d want d28 y5", bus.date, bus.year);
    end
    // Field wrap without carry, and sel 000 is a no-op.
    edit(3'd3, 24);
    edit(3'd0, 3);
    total++;
    if (got !== pack(0, 0, 0, 6, 28, 2, 5)) begin
      bad++;
      $display("FAIL hour_wrap_sel0: got %h want %h", got, pack(0, 0, 0, 6, 28, 2, 5));
    end
    total++;
    if (bus.sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL set_no_tick: got %b want 0", bus.sec_tick);
    end
  endtask

  task automatic test_async_reset();
    logic exp_tick;
    start_set();
    edit(3'd1, 37);
    @(negedge clk);
    bus.set_en = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (bus.sec !== 6'd38) begin
      bad++;
      $display("FAIL pre_reset_sec: got %0d want 38", bus.sec);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (got !== pack(0, 0, 0, 6, 1, 1, 0) || bus.sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", got, pack(0, 0, 0, 6, 1, 1, 0));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      exp_tick = (i == 3);
      total++;
      if (bus.sec_tick !== exp_tick) begin
        bad++;
        $display("FAIL post_reset_tick%0d: got %b want %b", i + 1, bus.sec_tick, exp_tick);
      end
    end
    total++;
    if (bus.sec !== 6'd1) begin
      bad++;
      $display("FAIL post_reset_sec: got %0d want 1", bus.sec);
    end
  endtask

  // Sequence and report
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.set_en = 1'b0;
    bus.set_sel = 3'd0;
    bus.inc = 1'b0;
`ifdef CAL_DEC_EN
    bus.dec = 1'b0;
`endif
    test_reset();
    test_day_rollover();
    test_leap();
    test_year_wrap();
    test_set_edits();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
